jacobi_pair_scheduler: RTL and testbench

Sequencer that walks the Jacobi eigenvalue engine through its rotation pairs. For an N×N symmetric matrix held in the shared dual-port BRAM, it emits one (p,q) index pair per rotation in cyclic-by-row order, together with the BRAM addresses of the a_pp, a_qq and a_pq elements. It counts sweeps and stops after a fixed sweep budget or earlier on a convergence flag. It sits between the main controller, which consumes pairs over a valid/ready handshake, and the host-side start/abort controls.

---
 rtl/jacobi_pair_scheduler.sv | 120 ++++++++++++
 tb/tb_jacobi_pair_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/jacobi_pair_scheduler.sv
// Walks cyclic-by-row (p,q) rotation pairs for the Jacobi engine, with
// registered BRAM addresses, sweep counting, convergence exit and abort.
module jacobi_pair_scheduler #(
   parameter int N      = 4,
   parameter int SWEEPS = 6,
   parameter int IDX_W  = 2,
   parameter int ADDR_W = 4,
   parameter int SWP_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              converged_i,
   output logic              pair_vld_o,
   input  logic              pair_rdy_i,
   output logic [IDX_W-1:0]  pair_p_o,
   output logic [IDX_W-1:0]  pair_q_o,
   output logic [ADDR_W-1:0] addr_pp_o,
   output logic [ADDR_W-1:0] addr_qq_o,
   output logic [ADDR_W-1:0] addr_pq_o,
   output logic              last_in_sweep_o,
   output logic [SWP_W-1:0]  sweep_idx_o,
   output logic              busy_o,
   output logic              done_o
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [IDX_W-1:0]  ONE_I  = IDX_W'(1);
   localparam logic [IDX_W-1:0]  P_LAST = IDX_W'(N - 2);
   localparam logic [IDX_W-1:0]  Q_LAST = IDX_W'(N - 1);
   localparam logic [SWP_W-1:0]  S_LAST = SWP_W'(SWEEPS - 1);
   localparam logic [ADDR_W-1:0] N_A    = ADDR_W'(N);

   state_t             st, st_n;
   logic [IDX_W-1:0]   p, q, p_n, q_n;
   logic [SWP_W-1:0]   sw, sw_n;
   logic [ADDR_W-1:0]  pa, qa;
   logic               accept;

   assign accept = (st == RUN) && pair_rdy_i;

   always_comb begin
      st_n = st;
      p_n  = p;
      q_n  = q;
      sw_n = sw;
      case (st)
         IDLE: if (start_i) begin
            st_n = RUN;
            p_n  = '0;
            q_n  = ONE_I;
            sw_n = '0;
         end
         RUN: if (accept) begin
            if (q < Q_LAST) begin
               q_n = q + ONE_I;
            end else if (p < P_LAST) begin
               p_n = p + ONE_I;
               q_n = p + ONE_I + ONE_I;
            end else if (converged_i || sw == S_LAST) begin
               st_n = DONE;
            end else begin
               sw_n = sw + SWP_W'(1);
               p_n  = '0;
               q_n  = ONE_I;
            end
         end
         default: st_n = IDLE;
      endcase
      // abort wins over start and discards a coincident accept
      if (abort_i) st_n = IDLE;
   end

   assign pa = ADDR_W'(p_n);
   assign qa = ADDR_W'(q_n);

   // Index/address registers only hold a value while in RUN, so IDLE and
   // DONE present all-zero pair outputs; a stalled pair reloads itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         st              <= IDLE;
         p               <= '0;
         q               <= '0;
         sw              <= '0;
         addr_pp_o       <= '0;
         addr_qq_o       <= '0;
         addr_pq_o       <= '0;
         last_in_sweep_o <= 1'b0;
      end else begin
         st <= st_n;
         if (st_n == RUN) begin
            p               <= p_n;
            q               <= q_n;
            sw              <= sw_n;
            addr_pp_o       <= pa * N_A + pa;
            addr_qq_o       <= qa * N_A + qa;
            addr_pq_o       <= pa * N_A + qa;
            last_in_sweep_o <= (p_n == P_LAST) && (q_n == Q_LAST);
         end else begin
            p               <= '0;
            q               <= '0;
            sw              <= '0;
            addr_pp_o       <= '0;
            addr_qq_o       <= '0;
            addr_pq_o       <= '0;
            last_in_sweep_o <= 1'b0;
         end
      end
   end

   assign pair_p_o    = p;
   assign pair_q_o    = q;
   assign sweep_idx_o = sw;
   assign pair_vld_o  = (st == RUN);
   assign busy_o      = (st == RUN);
   assign done_o      = (st == DONE);

endmodule

// File: tb/tb_jacobi_pair_scheduler.sv
// Directed bench: three schedulers (4x4/2 sweeps, 4x4/6 sweeps, 2x2/3 sweeps)
// share one set of control inputs; each scenario watches the relevant one.
module tb_jacobi_pair_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, abort, conv, rdy;

   logic       a_vld, a_last, a_busy, a_done;
   logic [1:0] a_p, a_q, a_sw;
   logic [3:0] a_pp, a_qq, a_pq;
   logic       b_vld, b_last, b_busy, b_done;
   logic [1:0] b_p, b_q;
   logic [2:0] b_sw;
   logic [3:0] b_pp, b_qq, b_pq;
   logic       c_vld, c_last, c_busy, c_done, c_p, c_q;
   logic [1:0] c_sw, c_pp, c_qq, c_pq;

   jacobi_pair_scheduler #(.N(4), .SWEEPS(2), .IDX_W(2), .ADDR_W(4), .SWP_W(2)) u_a (
      .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .converged_i(conv),
      .pair_vld_o(a_vld), .pair_rdy_i(rdy), .pair_p_o(a_p), .pair_q_o(a_q),
      .addr_pp_o(a_pp), .addr_qq_o(a_qq), .addr_pq_o(a_pq), .last_in_sweep_o(a_last),
      .sweep_idx_o(a_sw), .busy_o(a_busy), .done_o(a_done));

   jacobi_pair_scheduler #(.N(4), .SWEEPS(6), .IDX_W(2), .ADDR_W(4), .SWP_W(3)) u_b (
      .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .converged_i(conv),
      .pair_vld_o(b_vld), .pair_rdy_i(rdy), .pair_p_o(b_p), .pair_q_o(b_q),
      .addr_pp_o(b_pp), .addr_qq_o(b_qq), .addr_pq_o(b_pq), .last_in_sweep_o(b_last),
      .sweep_idx_o(b_sw), .busy_o(b_busy), .done_o(b_done));

   jacobi_pair_scheduler #(.N(2), .SWEEPS(3), .IDX_W(1), .ADDR_W(2), .SWP_W(2)) u_c (
      .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .converged_i(conv),
      .pair_vld_o(c_vld), .pair_rdy_i(rdy), .pair_p_o(c_p), .pair_q_o(c_q),
      .addr_pp_o(c_pp), .addr_qq_o(c_qq), .addr_pq_o(c_pq), .last_in_sweep_o(c_last),
      .sweep_idx_o(c_sw), .busy_o(c_busy), .done_o(c_done));

   typedef struct {
      logic [1:0] p, q;
      logic [3:0] pp, qq, pq;
      logic       last;
   } vec_t;
   vec_t tbl [6];

   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [20:0] pk(logic v, logic [1:0] p, logic [1:0] q, logic [3:0] pp,
                                      logic [3:0] qq, logic [3:0] pq, logic l, logic [2:0] s);
      return {v, p, q, pp, qq, pq, l, s};
   endfunction

   function automatic logic [22:0] act_a();
      return {pk(a_vld, a_p, a_q, a_pp, a_qq, a_pq, a_last, {1'b0, a_sw}), a_busy, a_done};
   endfunction
   function automatic logic [22:0] act_b();
      return {pk(b_vld, b_p, b_q, b_pp, b_qq, b_pq, b_last, b_sw), b_busy, b_done};
   endfunction
   function automatic logic [22:0] act_c();
      return {pk(c_vld, {1'b0, c_p}, {1'b0, c_q}, {2'b0, c_pp}, {2'b0, c_qq}, {2'b0, c_pq},
                 c_last, {1'b0, c_sw}), c_busy, c_done};
   endfunction

   // expected running 4x4 pair k (sweep index k/6), busy=1, done=0
   function automatic logic [22:0] exp4(int k);
      vec_t v;
      v = tbl[k % 6];
      return {pk(1'b1, v.p, v.q, v.pp, v.qq, v.pq, v.last, 3'(k / 6)), 1'b1, 1'b0};
   endfunction
   // 2x2: only pair (0,1), pp=0 qq=3 pq=1, always last
   function automatic logic [22:0] exp2(int s);
      return {pk(1'b1, 2'd0, 2'd1, 4'd0, 4'd3, 4'd1, 1'b1, 3'(s)), 1'b1, 1'b0};
   endfunction

   localparam logic [22:0] IDLE_V = 23'd0;
   localparam logic [22:0] DONE_V = 23'd1;

   task automatic chk(input string nm, input logic [22:0] act, input logic [22:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic quiesce();
      start = 1'b0; rdy = 1'b0; conv = 1'b0; abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   initial begin
      int k, cyc;
      tbl[0] = '{2'd0, 2'd1, 4'd0,  4'd5,  4'd1,  1'b0};
      tbl[1] = '{2'd0, 2'd2, 4'd0,  4'd10, 4'd2,  1'b0};
      tbl[2] = '{2'd0, 2'd3, 4'd0,  4'd15, 4'd3,  1'b0};
      tbl[3] = '{2'd1, 2'd2, 4'd5,  4'd10, 4'd6,  1'b0};
      tbl[4] = '{2'd1, 2'd3, 4'd5,  4'd15, 4'd7,  1'b0};
      tbl[5] = '{2'd2, 2'd3, 4'd10, 4'd15, 4'd11, 1'b1};

      rst = 1'b1; start = 1'b0; abort = 1'b0; conv = 1'b0; rdy = 1'b0;
      step(); step();
      rst = 1'b0;
      chk("reset_a", act_a(), IDLE_V);
      chk("reset_b", act_b(), IDLE_V);
      chk("reset_c", act_c(), IDLE_V);

      // full run, rdy held high: 12 back-to-back pairs, then DONE
      rdy = 1'b1;
      pulse_start();
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("run_a_%0d", i), act_a(), exp4(i));
         step();
      end
      chk("run_a_done", act_a(), DONE_V);
      step();
      chk("run_a_idle", act_a(), IDLE_V);
      quiesce();

      // backpressure: rdy 1,0,0 repeating; every cycle shows the pending pair
      pulse_start();
      k = 0; cyc = 0;
      while (k < 12 && cyc < 60) begin
         chk($sformatf("bp_a_%0d", cyc), act_a(), exp4(k));
         rdy = (cyc % 3 == 0);
         step();
         if (rdy) k++;
         cyc++;
      end
      chk("bp_accepts", 23'(k), 23'd12);
      chk("bp_done", act_a(), DONE_V);
      quiesce();

      // early exit on convergence at end of second sweep (also high mid-sweep)
      rdy = 1'b1;
      pulse_start();
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("conv_b_%0d", i), act_b(), exp4(i));
         conv = (i == 11) || (i == 2);
         step();
         conv = 1'b0;
      end
      chk("conv_b_done", act_b(), DONE_V);
      step();
      chk("conv_b_no13", act_b(), IDLE_V);
      quiesce();

      // abort while 4th pair is presented, coinciding with an accept
      rdy = 1'b1;
      pulse_start();
      for (int i = 0; i < 3; i++) step();
      chk("abort_pre", act_a(), exp4(3));
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_idle", act_a(), IDLE_V);
      step();
      chk("abort_nodone", act_a(), IDLE_V);
      pulse_start();
      chk("abort_restart", act_a(), exp4(0));
      quiesce();

      // 2x2, 3 sweeps: start+abort together, stall, start during RUN
      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      chk("c_start_abort", act_c(), IDLE_V);
      pulse_start();
      chk("c_sw0", act_c(), exp2(0));
      step();
      chk("c_sw0_hold", act_c(), exp2(0));
      rdy = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      chk("c_sw1", act_c(), exp2(1));
      step();
      chk("c_sw2", act_c(), exp2(2));
      step();
      chk("c_done", act_c(), DONE_V);
      step();
      chk("c_idle", act_c(), IDLE_V);
      quiesce();

      // synchronous reset at the 5th pair
      rdy = 1'b1;
      pulse_start();
      for (int i = 0; i < 4; i++) step();
      chk("rst_pre", act_a(), exp4(4));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_idle", act_a(), IDLE_V);
      step();
      chk("rst_nodone", act_a(), IDLE_V);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
